// File: rtl/wb_port_arbiter_pkg.sv
// Shared CPU definitions for the write-back port arbiter: default sizes,
// register-index width and the result-queue entry layout.
package wb_port_arbiter_pkg;
    localparam int WB_DEPTH_DEF    = 2;
    localparam int WB_MAX_WAIT_DEF = 4;
    localparam int REG_IDX_W       = 5;
    localparam int XLEN            = 32;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;

    typedef struct packed {
        logic            live;
        reg_idx_t        rd;
        logic [XLEN-1:0] data;
    } wb_entry_t;

    function automatic logic [31:0] onehot_rd(input reg_idx_t rd);
        return 32'd1 << rd;
    endfunction
endpackage

// File: rtl/wb_result_fifo.sv
// MDU result queue. Each entry carries a live bit that a younger pipeline
// write to the same rd clears, including an entry pushed in that same cycle.
module wb_result_fifo
    import wb_port_arbiter_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH_DEF,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  wb_entry_t        i_push_entry,
    input  logic             i_pop,
    input  logic             i_squash,
    input  reg_idx_t         i_squash_rd,
    output logic [CNT_W-1:0] o_count,
    output wb_entry_t        o_head,
    output logic [31:0]      o_pending_mask
);
    wb_entry_t        r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr, r_rptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push_live;
    logic [31:0]      w_mask;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_push_live = i_push_entry.live &&
                         !(i_squash && (i_push_entry.rd == i_squash_rd));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++)
                if (i_squash && (r_mem[i].rd == i_squash_rd)) r_mem[i].live <= 1'b0;
            // Dropping live on pop keeps the pending mask free of freed slots.
            if (i_pop) begin
                r_mem[r_rptr].live <= 1'b0;
                r_rptr             <= ptr_next(r_rptr);
            end
            if (i_push) begin
                r_mem[r_wptr] <= '{live: w_push_live, rd: i_push_entry.rd,
                                   data: i_push_entry.data};
                r_wptr        <= ptr_next(r_wptr);
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_comb begin
        w_mask = '0;
        for (int i = 0; i < DEPTH; i++)
            if (r_mem[i].live && (r_mem[i].rd != '0)) w_mask = w_mask | onehot_rd(r_mem[i].rd);
    end

    assign o_count        = r_count;
    assign o_head         = r_mem[r_rptr];
    assign o_pending_mask = w_mask;
endmodule

// File: rtl/wb_port_arbiter.sv
// Arbitrates the single register-file write port between the pipeline WB
// stage and queued MDU results, with a starvation bound on the queue.
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int DEPTH    = WB_DEPTH_DEF,
    parameter int MAX_WAIT = WB_MAX_WAIT_DEF
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_pipe_we,
    input  logic [REG_IDX_W-1:0] i_pipe_rd,
    input  logic [31:0]          i_pipe_data,
    input  logic                 i_mdu_valid,
    input  logic [REG_IDX_W-1:0] i_mdu_rd,
    input  logic [31:0]          i_mdu_data,
    output logic                 o_mdu_ready,
    output logic                 o_stall,
    output logic                 o_rf_we,
    output logic [REG_IDX_W-1:0] o_rf_rd,
    output logic [31:0]          o_rf_data,
    output logic [31:0]          o_pending_mask
);
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int WAIT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

    logic [CNT_W-1:0]     w_count;
    wb_entry_t            w_head, w_push_entry;
    logic                 w_full, w_empty, w_stall, w_push, w_pop, w_pipe_win;
    logic [WAIT_W-1:0]    r_wait;
    logic                 r_rf_we;
    logic [REG_IDX_W-1:0] r_rf_rd;
    logic [31:0]          r_rf_data;

    assign w_full       = (w_count == CNT_W'(DEPTH));
    assign w_empty      = (w_count == '0);
    assign w_stall      = w_full || (!w_empty && (r_wait == WAIT_W'(MAX_WAIT)));
    assign w_push       = i_mdu_valid && !w_full;
    assign w_pipe_win   = !w_stall && i_pipe_we;
    assign w_pop        = !w_empty && (w_stall || !i_pipe_we);
    assign w_push_entry = '{live: 1'b1, rd: i_mdu_rd, data: i_mdu_data};

    wb_result_fifo #(.DEPTH(DEPTH)) u_fifo (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_push         (w_push),
        .i_push_entry   (w_push_entry),
        .i_pop          (w_pop),
        .i_squash       (w_pipe_win),
        .i_squash_rd    (i_pipe_rd),
        .o_count        (w_count),
        .o_head         (w_head),
        .o_pending_mask (o_pending_mask)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wait    <= '0;
            r_rf_we   <= 1'b0;
            r_rf_rd   <= '0;
            r_rf_data <= '0;
        end else begin
            // Counts only pipeline wins that leave a queued result waiting.
            if (w_pop || w_empty)
                r_wait <= '0;
            else if (w_pipe_win && (r_wait != WAIT_W'(MAX_WAIT)))
                r_wait <= r_wait + 1'b1;

            if (w_pipe_win) begin
                r_rf_we   <= (i_pipe_rd != '0);
                r_rf_rd   <= i_pipe_rd;
                r_rf_data <= i_pipe_data;
            end else if (w_pop) begin
                r_rf_we   <= w_head.live && (w_head.rd != '0);
                r_rf_rd   <= w_head.rd;
                r_rf_data <= w_head.data;
            end else begin
                r_rf_we   <= 1'b0;
            end
        end
    end

    assign o_mdu_ready = !w_full;
    assign o_stall     = w_stall;
    assign o_rf_we     = r_rf_we;
    assign o_rf_rd     = r_rf_rd;
    assign o_rf_data   = r_rf_data;
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed checks of the write-back port arbiter with default DEPTH=2, MAX_WAIT=4.
module tb_wb_port_arbiter;
    logic        clk, rst_n;
    logic        pipe_we, mdu_valid;
    logic [4:0]  pipe_rd, mdu_rd;
    logic [31:0] pipe_data, mdu_data;
    logic        mdu_ready, stall, rf_we;
    logic [4:0]  rf_rd;
    logic [31:0] rf_data, pmask;
    int          n_chk, n_fail;

    wb_port_arbiter dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_pipe_we(pipe_we), .i_pipe_rd(pipe_rd), .i_pipe_data(pipe_data),
        .i_mdu_valid(mdu_valid), .i_mdu_rd(mdu_rd), .i_mdu_data(mdu_data),
        .o_mdu_ready(mdu_ready), .o_stall(stall),
        .o_rf_we(rf_we), .o_rf_rd(rf_rd), .o_rf_data(rf_data),
        .o_pending_mask(pmask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rf(input string tag, input logic we, input logic [4:0] rd, input logic [31:0] d);
        chk({tag, ".we"}, {31'd0, rf_we}, {31'd0, we});
        if (we) begin
            chk({tag, ".rd"}, {27'd0, rf_rd}, {27'd0, rd});
            chk({tag, ".data"}, rf_data, d);
        end
    endtask

    initial begin
        n_chk = 0; n_fail = 0;
        rst_n = 1'b0; pipe_we = 0; pipe_rd = 0; pipe_data = 0;
        mdu_valid = 0; mdu_rd = 0; mdu_data = 0;
        #3;
        chk("rst.ready", {31'd0, mdu_ready}, 32'd1);
        chk("rst.stall", {31'd0, stall}, 32'd0);
        chk("rst.mask", pmask, 32'd0);
        chk("rst.rfwe", {31'd0, rf_we}, 32'd0);
        chk("rst.rfrd", {27'd0, rf_rd}, 32'd0);
        chk("rst.rfdata", rf_data, 32'd0);
        #9 rst_n = 1'b1;

        // MDU result on idle pipeline
        mdu_valid = 1; mdu_rd = 5; mdu_data = 32'h7;
        tick(); mdu_valid = 0;
        chk("t34.mask1", pmask, 32'h20);
        chk("t34.we0", {31'd0, rf_we}, 32'd0);
        tick();
        rf("t34.pop", 1, 5, 32'h7);
        chk("t34.mask0", pmask, 32'd0);
        tick();
        chk("t34.idle", {31'd0, rf_we}, 32'd0);
        chk("t34.hold", {27'd0, rf_rd}, 32'd5);

        // Starvation bound with pipeline held
        pipe_we = 1; pipe_rd = 1; pipe_data = 32'h100;
        mdu_valid = 1; mdu_rd = 6; mdu_data = 32'h11;
        tick(); mdu_valid = 0;
        rf("t35.w0", 1, 1, 32'h100);
        chk("t35.mask", pmask, 32'h40);
        tick(); tick(); tick();
        chk("t35.nostall3", {31'd0, stall}, 32'd0);
        rf("t35.w3", 1, 1, 32'h100);
        tick();
        chk("t35.stall", {31'd0, stall}, 32'd1);
        tick();
        rf("t35.mdu", 1, 6, 32'h11);
        chk("t35.unstall", {31'd0, stall}, 32'd0);
        tick();
        rf("t35.pipe", 1, 1, 32'h100);
        pipe_we = 0;
        tick();
        chk("t35.idle", {31'd0, rf_we}, 32'd0);
        chk("t35.holdd", rf_data, 32'h100);

        // Fill queue, drain in order
        pipe_we = 1; pipe_rd = 2; pipe_data = 32'h22;
        mdu_valid = 1; mdu_rd = 7; mdu_data = 32'h77;
        tick();
        mdu_rd = 8; mdu_data = 32'h88;
        chk("t36.ready1", {31'd0, mdu_ready}, 32'd1);
        tick(); mdu_valid = 0;
        chk("t36.ready0", {31'd0, mdu_ready}, 32'd0);
        chk("t36.stall", {31'd0, stall}, 32'd1);
        chk("t36.mask", pmask, 32'h180);
        tick(); pipe_we = 0;
        rf("t36.x7", 1, 7, 32'h77);
        chk("t36.ready", {31'd0, mdu_ready}, 32'd1);
        chk("t36.mask8", pmask, 32'h100);
        tick();
        rf("t36.x8", 1, 8, 32'h88);
        chk("t36.empty", pmask, 32'd0);

        // Younger pipeline write squashes queued x9
        pipe_we = 1; pipe_rd = 3; pipe_data = 32'h33;
        mdu_valid = 1; mdu_rd = 9; mdu_data = 32'hAA;
        tick(); mdu_valid = 0;
        chk("t37.mask", pmask, 32'h200);
        pipe_rd = 9; pipe_data = 32'hBB;
        tick(); pipe_we = 0;
        rf("t37.bb", 1, 9, 32'hBB);
        chk("t37.mask0", pmask, 32'd0);
        tick();
        chk("t37.dead", {31'd0, rf_we}, 32'd0);
        chk("t37.stall", {31'd0, stall}, 32'd0);

        // Same-cycle push and squash
        pipe_we = 1; pipe_rd = 10; pipe_data = 32'h1;
        mdu_valid = 1; mdu_rd = 10; mdu_data = 32'h2;
        tick(); mdu_valid = 0; pipe_we = 0;
        rf("tsq.pipe", 1, 10, 32'h1);
        chk("tsq.mask", pmask, 32'd0);
        tick();
        chk("tsq.dead", {31'd0, rf_we}, 32'd0);

        // rd=0 MDU result
        mdu_valid = 1; mdu_rd = 0; mdu_data = 32'h55;
        tick(); mdu_valid = 0;
        chk("t38.mask", pmask, 32'd0);
        tick();
        chk("t38.we", {31'd0, rf_we}, 32'd0);
        chk("t38.ready", {31'd0, mdu_ready}, 32'd1);

        // Reset with a full queue
        pipe_we = 1; pipe_rd = 4; pipe_data = 32'h44;
        mdu_valid = 1; mdu_rd = 11; mdu_data = 32'hB1;
        tick();
        mdu_rd = 12; mdu_data = 32'hB2;
        tick(); mdu_valid = 0; pipe_we = 0;
        chk("t39.full", {31'd0, mdu_ready}, 32'd0);
        rf("t39.pre", 1, 4, 32'h44);
        #1 rst_n = 1'b0;
        #1;
        chk("t39.we", {31'd0, rf_we}, 32'd0);
        chk("t39.rd", {27'd0, rf_rd}, 32'd0);
        chk("t39.data", rf_data, 32'd0);
        chk("t39.ready", {31'd0, mdu_ready}, 32'd1);
        chk("t39.stall", {31'd0, stall}, 32'd0);
        chk("t39.mask", pmask, 32'd0);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t39.nostale", {31'd0, rf_we}, 32'd0);
        end
        chk("t39.mask2", pmask, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/wb_port_arbiter.md
WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 SHALL have parameter DEPTH, 2, number of entries in the MDU result queue (minimum 2).
REQ-002 SHALL have parameter MAX_WAIT, 4, consecutive pipeline-won cycles tolerated while the queue is non-empty.
REQ-003 CLK  in  1  single clock; all state updates on rising edge.
REQ-004 RST  in  1  reset; asynchronous, active-low.
REQ-005 PIPE_WE  in  1  pipeline WB stage requests a register-file write.
REQ-006 PIPE_RD  in  5  pipeline destination register.
REQ-007 PIPE_DATA  in  32  pipeline write data.
REQ-008 MDU_VALID  in  1  multi-cycle MUL/DIV unit offers a result.
REQ-009 MDU_RD  in  5  MDU destination register.
REQ-010 MDU_DATA  in  32  MDU result.
REQ-011 MDU_READY  out  1  queue can accept the MDU result this cycle.
REQ-012 STALL  out  1  pipeline write not consumed this cycle; WB stage holds.
REQ-013 RF_WE  out  1  register-file write enable, registered.
REQ-014 RF_RD  out  5  register-file write address, registered.
REQ-015 RF_DATA  out  32  register-file write data, registered.
REQ-016 PENDING_MASK  out  32  bit n set when a live queue entry targets xn; for the hazard unit.

Function
REQ-017 MDU push SHALL occur when MDU_VALID and MDU_READY are both 1.
REQ-018 MDU_READY SHALL be 1 when queue count < DEPTH; it is a function of registered state only.
REQ-019 STALL SHALL be 1 when queue count == DEPTH, or when the wait counter == MAX_WAIT and the queue is non-empty; otherwise 0; Moore output.
REQ-020 Grant when STALL=0: the pipeline wins if PIPE_WE=1; otherwise the queue head pops if the queue is non-empty.
REQ-021 Grant when STALL=1: the queue head pops; PIPE_* inputs are ignored and not written.
REQ-022 The winner's rd/data SHALL appear on RF_RD/RF_DATA with RF_WE=1 on the next cycle (latency 1); with no winner, RF_WE=0 and RF_RD/RF_DATA hold.
REQ-023 A winning write with rd==0 SHALL produce RF_WE=0, but a popped entry still leaves the queue.
REQ-024 Each queue entry carries a live bit; an accepted pipeline write (REQ-020) SHALL clear the live bit of every entry, including one pushed the same cycle, whose rd equals PIPE_RD, because the pipeline write is younger in program order.
REQ-025 A popped entry with live=0 SHALL produce RF_WE=0 and still consume its pop cycle.
REQ-026 Push and pop in the same cycle are allowed; the count is unchanged; a push when full is impossible by REQ-018.
REQ-027 Queue pointers wrap modulo DEPTH.
REQ-028 Wait counter: increments when the queue is non-empty and the pipeline wins; clears on any pop or when the queue is empty; saturates at MAX_WAIT.
REQ-029 PENDING_MASK SHALL be the OR of one-hot(rd) over live entries with rd!=0, from registered state.

Reset
REQ-030 When RST=0, all of the following SHALL clear asynchronously: queue count, pointers, live bits, wait counter, RF_WE, RF_RD, RF_DATA.
REQ-031 During and after reset: MDU_READY=1, STALL=0, PENDING_MASK=0; any mid-operation queue contents are discarded.

Structure
REQ-032 The DEPTH and MAX_WAIT defaults and the register-index width (5) SHALL live in the shared CPU package.
REQ-033 The queue SHALL be a sub-module wb_result_fifo (data, rd, live bit, per-entry squash-by-rd port); arbitration, counter and output registers stay in the top level.

Verification
REQ-034 MDU push x5=0x0000_0007 on an idle pipeline -> next cycle RF_WE=1, RF_RD=5, RF_DATA=7; PENDING_MASK bit5 is 1 for exactly one cycle.
REQ-035 PIPE_WE held 1 every cycle, one MDU push x6=0x11 -> pipeline wins 4 cycles, then STALL=1 for one cycle, then RF writes x6=0x11 and the held pipeline write follows next cycle.
REQ-036 Two MDU pushes (x7, x8) while the pipeline writes -> count=2, MDU_READY=0, STALL=1; drains x7 then x8 in order; MDU_READY returns to 1 after the first pop.
REQ-037 Queue holds x9=0xAA; pipeline writes x9=0xBB -> RF gets 0xBB; the later pop of x9 gives RF_WE=0; PENDING_MASK bit9 clears the cycle after the pipeline write.
REQ-038 MDU push with rd=0 -> pop with RF_WE=0.
REQ-039 RST asserted mid-drain with a full queue -> outputs clear immediately; after release no stale write occurs.
